// File: rtl/lshift_pipe.sv
// Three-stage elastic left shifter (4 / 2 / 1 bit stages) with valid/ready handshake.
// Define LSHIFT_ROTATE_EN to make every stage rotate left instead of zero-filling.
module lshift_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    input  logic [2:0] shmag,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out
);

    logic       v1;
    logic       v2;
    logic       v3;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [1:0] m1;
    logic       m2;

    logic       rdy1;
    logic       rdy2;
    logic       rdy3;

    logic [7:0] s1_data;
    logic [7:0] s2_data;
    logic [7:0] s3_data;

    // A stage can take a new word if it is empty or its occupant moves on this cycle.
    assign rdy3 = !v3 | out_ready;
    assign rdy2 = !v2 | rdy3;
    assign rdy1 = !v1 | rdy2;

    assign in_ready  = rdy1 & !rst;
    assign out_valid = v3;
    assign out       = d3;

    always_comb begin
        s1_data = in;
        s2_data = d1;
        s3_data = d2;
`ifdef LSHIFT_ROTATE_EN
        if (shmag[2]) s1_data = {in[3:0], in[7:4]};
        if (m1[1])    s2_data = {d1[5:0], d1[7:6]};
        if (m2)       s3_data = {d2[6:0], d2[7]};
`else
        if (shmag[2]) s1_data = {in[3:0], 4'b0000};
        if (m1[1])    s2_data = {d1[5:0], 2'b00};
        if (m2)       s3_data = {d2[6:0], 1'b0};
`endif
    end

    // Data and shift bits only load alongside a valid word; bubbles leave them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= 8'h00;
            d2 <= 8'h00;
            d3 <= 8'h00;
            m1 <= 2'b00;
            m2 <= 1'b0;
        end else begin
            if (rdy1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    d1 <= s1_data;
                    m1 <= shmag[1:0];
                end
            end
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= s2_data;
                    m2 <= m1[0];
                end
            end
            if (rdy3) begin
                v3 <= v2;
                if (v2) begin
                    d3 <= s3_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_lshift_pipe.sv
// Self-checking bench for lshift_pipe: directed vector table, corner sequences,
// and a randomized handshake run against a queue-based reference model.
module tb_lshift_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic [2:0] shmag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lshift_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .shmag     (shmag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] w;
        w = {8'h00, d} << s;
`ifdef LSHIFT_ROTATE_EN
        return w[7:0] | w[15:8];
`else
        return w[7:0];
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [2:0] sh;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] b2b_exp[8];
    logic [7:0] sb[$];

    initial begin
        int acc;
        int cyc;

`ifdef LSHIFT_ROTATE_EN
        vecs[0] = '{8'hB3, 3'd3, 8'h9D};
        vecs[1] = '{8'hFF, 3'd7, 8'hFF};
        vecs[2] = '{8'hFF, 3'd4, 8'hFF};
        vecs[3] = '{8'h81, 3'd1, 8'h03};
`else
        vecs[0] = '{8'hB3, 3'd3, 8'h98};
        vecs[1] = '{8'hFF, 3'd7, 8'h80};
        vecs[2] = '{8'hFF, 3'd4, 8'hF0};
        vecs[3] = '{8'h81, 3'd1, 8'h02};
`endif
        vecs[4] = '{8'h5A, 3'd1, 8'hB4};
        vecs[5] = '{8'hA5, 3'd0, 8'hA5};
        vecs[6] = '{8'h01, 3'd0, 8'h01};
        b2b_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in        = 8'hC3;
        shmag     = 3'd2;
        out_ready = 1'b1;
        #12;
        check("reset out_valid", 8'(out_valid), 8'h00);
        check("reset out", out, 8'h00);
        check("reset in_ready", 8'(in_ready), 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single words: accepted at one edge, on out after the next two edges.
        for (int i = 0; i < 7; i++) begin
            in_valid  = 1'b1;
            in        = vecs[i].din;
            shmag     = vecs[i].sh;
            out_ready = 1'b1;
            #1;
            check("vec in_ready", 8'(in_ready), 8'h01);
            tick();
            in_valid = 1'b0;
            in       = 8'($urandom);
            shmag    = 3'($urandom);
            tick();
            check("vec early out_valid", 8'(out_valid), 8'h00);
            tick();
            check("vec out_valid", 8'(out_valid), 8'h01);
            check("vec out", out, vecs[i].exp);
            tick();
            check("vec drained", 8'(out_valid), 8'h00);
        end

        // Back-to-back 8'h01 with shmag 0..7: one result per cycle, no bubbles.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                in_valid = 1'b1;
                in       = 8'h01;
                shmag    = 3'(k);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 2) begin
                check("b2b out_valid", 8'(out_valid), 8'h01);
                check("b2b out", out, b2b_exp[k-2]);
            end
        end
        tick();

        // Fill with out_ready low, verify freeze, then release.
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in       = (j == 0) ? 8'h11 : (j == 1) ? 8'h22 : 8'h33;
            shmag    = (j == 0) ? 3'd1 : (j == 1) ? 3'd2 : 3'd0;
            #1;
            check("fill in_ready", 8'(in_ready), 8'h01);
            tick();
        end
        in    = 8'h44;
        shmag = 3'd0;
        #1;
        check("full in_ready", 8'(in_ready), 8'h00);
        check("full out_valid", 8'(out_valid), 8'h01);
        check("full out", out, 8'h22);
        tick();
        check("frozen out 1", out, 8'h22);
        tick();
        check("frozen out 2", out, 8'h22);
        check("frozen in_ready", 8'(in_ready), 8'h00);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("release in_ready", 8'(in_ready), 8'h01);
        check("release out 0", out, 8'h22);
        tick();
        check("release out_valid 1", 8'(out_valid), 8'h01);
        check("release out 1", out, 8'h88);
        tick();
        check("release out_valid 2", 8'(out_valid), 8'h01);
        check("release out 2", out, 8'h33);
        tick();
        check("release drained", 8'(out_valid), 8'h00);

        // Reset with two words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 8'h0F;
        shmag     = 3'd1;
        tick();
        in    = 8'hF0;
        shmag = 3'd2;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre-reset out", out, 8'h1E);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", 8'(out_valid), 8'h00);
        check("async reset out", out, 8'h00);
        check("async reset in_ready", 8'(in_ready), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        check("post-reset out_valid", 8'(out_valid), 8'h00);
        in_valid = 1'b1;
        in       = 8'h5A;
        shmag    = 3'd1;
        tick();
        in_valid = 1'b0;
        check("post-reset stale 1", 8'(out_valid), 8'h00);
        tick();
        check("post-reset stale 2", 8'(out_valid), 8'h00);
        tick();
        check("post-reset out_valid", 8'(out_valid), 8'h01);
        check("post-reset out", out, 8'hB4);
        tick();

        // Random handshake run against a FIFO-order reference model.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in        = 8'($urandom);
            shmag     = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rnd in_ready", 8'(in_ready), 8'((sb.size() < 3) || out_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) fail_event("rnd spurious output");
                else check("rnd out", out, sb.pop_front());
            end
            if (in_valid && in_ready) begin
                sb.push_back(ref_shift(in, shmag));
                acc++;
            end
            tick();
            cyc++;
        end
        if (acc < 1000) fail_event("rnd timeout accepting words");

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 10 && sb.size() > 0; t++) begin
            #1;
            if (out_valid) check("drain out", out, sb.pop_front());
            tick();
        end
        if (sb.size() != 0) fail_event("drain words lost");
        #1;
        check("final out_valid", 8'(out_valid), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
